// File: rtl/alufpu_arbiter.sv
// alufpu_arbiter
// Shares a single combinational alufpu between two requesters.
// Round-robin arbitration in IDLE, one transaction in flight:
//   IDLE -> accept one request, latch its operation
//   EXEC -> drive latched operation onto the alufpu buses, capture result
//   RESP -> present result to the owner until it is consumed
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   reqN_valid/ready                 request handshake (N = 0, 1)
//   reqN_a/b/aluctrl/fp/fpuctrl      request operation
//   rspN_valid/ready                 response handshake
//   rsp_data, rsp_branch             registered shared result
//   busA/busB/ALUctrl                alufpu integer inputs
//   fbusA/fbusB/FPUctrl              alufpu floating-point inputs
//   ALUout/FPUout/branch             alufpu results
module alufpu_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [CTRL_W-1:0] req0_aluctrl,
  input  logic              req0_fp,
  input  logic              req0_fpuctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [CTRL_W-1:0] req1_aluctrl,
  input  logic              req1_fp,
  input  logic              req1_fpuctrl,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_branch,
  output logic [DATA_W-1:0] busA,
  output logic [DATA_W-1:0] busB,
  output logic [DATA_W-1:0] fbusA,
  output logic [DATA_W-1:0] fbusB,
  output logic [CTRL_W-1:0] ALUctrl,
  output logic              FPUctrl,
  input  logic [DATA_W-1:0] ALUout,
  input  logic [DATA_W-1:0] FPUout,
  input  logic              branch
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t              state, state_nx;
  logic                last_grant;
  logic                owner;
  logic [DATA_W-1:0]   op_a, op_b;
  logic [CTRL_W-1:0]   op_aluctrl;
  logic                op_fp;
  logic                op_fpuctrl;
  logic                grant0, grant1;
  logic                accept;
  logic                drive;
  logic                rsp_done;

  // Grant: lone requester wins; on a tie the one that did not win last.
  // Ready is also qualified by rst_n so it reads 0 while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && rst_n) begin
      if (req0_valid && (!req1_valid || last_grant))
        grant0 = 1'b1;
      else if (req1_valid)
        grant1 = 1'b1;
    end
  end

  assign accept     = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign rsp_done   = owner ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)   state_nx = EXEC;
      EXEC:                  state_nx = RESP;
      RESP:    if (rsp_done) state_nx = IDLE;
      default:               state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_aluctrl <= '0;
      op_fp      <= 1'b0;
      op_fpuctrl <= 1'b0;
      rsp_data   <= '0;
      rsp_branch <= 1'b0;
    end else begin
      if (accept) begin
        owner      <= grant1;
        last_grant <= grant1;
        op_a       <= grant1 ? req1_a       : req0_a;
        op_b       <= grant1 ? req1_b       : req0_b;
        op_aluctrl <= grant1 ? req1_aluctrl : req0_aluctrl;
        op_fp      <= grant1 ? req1_fp      : req0_fp;
        op_fpuctrl <= grant1 ? req1_fpuctrl : req0_fpuctrl;
      end
      if (state == EXEC) begin
        rsp_data   <= op_fp ? FPUout : ALUout;
        rsp_branch <= op_fp ? 1'b0 : branch;
      end
    end
  end

  // Buses carry the latched operation through EXEC and RESP, zero in IDLE.
  assign drive   = (state != IDLE);
  assign busA    = (drive && !op_fp) ? op_a       : '0;
  assign busB    = (drive && !op_fp) ? op_b       : '0;
  assign ALUctrl = (drive && !op_fp) ? op_aluctrl : '0;
  assign fbusA   = (drive &&  op_fp) ? op_a       : '0;
  assign fbusB   = (drive &&  op_fp) ? op_b       : '0;
  assign FPUctrl = drive && op_fp && op_fpuctrl;

  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) &&  owner;

endmodule
